// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - packs decoded RV32I fields into words and loads the program store
// Optional INST_ENC_CHECKSUM_EN adds an XOR checksum of every word written.
module inst_encoder_loader #(
  parameter int WIDTH    = 32,
  parameter int NUM_INST = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [12:0]      imm,
  input  logic             finish,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [4:0]       count,
  output logic             err,
`ifdef INST_ENC_CHECKSUM_EN
  output logic [WIDTH-1:0] checksum,
`endif
  output logic             done
);

  typedef enum logic [1:0] {LOAD, TERM, DONE} state_t;

  localparam logic [4:0] LAST = 5'(NUM_INST - 1);

  state_t           state, state_n;
  logic             we_n, err_n, done_n, accept, legal;
  logic [4:0]       count_n;
  logic [WIDTH-1:0] addr_n, wdata_n, slot_addr;
  logic [31:0]      enc;

  assign in_ready  = (state == LOAD) && (count < LAST);
  assign accept    = in_valid && in_ready;
  assign slot_addr = WIDTH'({count, 2'b00});

  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (opcode)
      7'b0110011: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      7'b0010011: begin
        // Shift-immediates carry funct7 in the upper immediate bits
        if (funct3 == 3'b001 || funct3 == 3'b101)
          enc = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else
          enc = {imm[11:0], rs1, funct3, rd, opcode};
      end
      7'b0000011: enc = {imm[11:0], rs1, funct3, rd, opcode};
      7'b0100011: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      7'b1100011: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    count_n = count;
    err_n   = 1'b0;
    done_n  = done;
    case (state)
      LOAD: begin
        if (accept) begin
          if (legal) begin
            we_n    = 1'b1;
            addr_n  = slot_addr;
            wdata_n = WIDTH'(enc);
            count_n = count + 5'd1;
          end else begin
            err_n = 1'b1;
          end
        end
        // A finish alongside an accept lands in TERM right behind that write
        if (finish) state_n = TERM;
      end
      TERM: begin
        we_n    = 1'b1;
        addr_n  = slot_addr;
        wdata_n = '0;
        done_n  = 1'b1;
        state_n = DONE;
      end
      default: state_n = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      count     <= count_n;
      err       <= err_n;
      done      <= done_n;
    end
  end

`ifdef INST_ENC_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)       checksum <= '0;
    else if (we_n) checksum <= checksum ^ wdata_n;
  end
`endif

endmodule
